// File: rtl/if_id_skid_reg_if.sv
// Handshake bundle between fetch, the IF/ID skid register and decode.
// The master is the environment (fetch + decode + redirect source) and the slave is the register.
interface if_id_skid_reg_if #(
    parameter int PC_W    = 32,
    parameter int INSTR_W = 32
);
    logic               in_valid;
    logic               in_ready;
    logic [PC_W-1:0]    in_pc;
    logic [INSTR_W-1:0] in_instr;
    logic               flush;
    logic               out_valid;
    logic               out_ready;
    logic [PC_W-1:0]    out_pc;
    logic [INSTR_W-1:0] out_instr;
    logic [1:0]         occupancy;

    modport slave (
        input  in_valid, in_pc, in_instr, flush, out_ready,
        output in_ready, out_valid, out_pc, out_instr, occupancy
    );

    modport master (
        output in_valid, in_pc, in_instr, flush, out_ready,
        input  in_ready, out_valid, out_pc, out_instr, occupancy
    );
endinterface

// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with a two-slot skid buffer and synchronous flush.
// Every output comes straight from a flop, so in_ready has no combinational path from out_ready.
module if_id_skid_reg #(
    parameter int                 PC_W      = 32,
    parameter int                 INSTR_W   = 32,
    parameter logic [INSTR_W-1:0] NOP_INSTR = 32'h00000013
) (
    input  logic               clk,
    input  logic               reset,
    if_id_skid_reg_if.slave    bus
);
    logic               main_valid_q, main_valid_d;
    logic [PC_W-1:0]    main_pc_q,    main_pc_d;
    logic [INSTR_W-1:0] main_instr_q, main_instr_d;
    logic               skid_valid_q, skid_valid_d;
    logic [PC_W-1:0]    skid_pc_q,    skid_pc_d;
    logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
    logic [1:0]         occupancy_q,  occupancy_d;
    logic               in_ready_q,   in_ready_d;
    logic               acc_s;
    logic               drn_s;

    assign acc_s = bus.in_valid & in_ready_q;
    assign drn_s = main_valid_q & bus.out_ready;

    // Next-state for both slots; flush wins over any handshake in the same cycle.
    always_comb begin
        main_valid_d = main_valid_q;
        main_pc_d    = main_pc_q;
        main_instr_d = main_instr_q;
        skid_valid_d = skid_valid_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        if (bus.flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
            main_instr_d = NOP_INSTR;
        end else begin
            case ({main_valid_q, skid_valid_q})
                2'b00: begin
                    if (acc_s) begin
                        main_valid_d = 1'b1;
                        main_pc_d    = bus.in_pc;
                        main_instr_d = bus.in_instr;
                    end else begin
                        main_instr_d = NOP_INSTR;
                    end
                end
                2'b10: begin
                    if (acc_s && drn_s) begin
                        main_pc_d    = bus.in_pc;
                        main_instr_d = bus.in_instr;
                    end else if (acc_s) begin
                        skid_valid_d = 1'b1;
                        skid_pc_d    = bus.in_pc;
                        skid_instr_d = bus.in_instr;
                    end else if (drn_s) begin
                        main_valid_d = 1'b0;
                        main_instr_d = NOP_INSTR;
                    end else begin
                        main_valid_d = main_valid_q;
                    end
                end
                2'b11: begin
                    // in_ready is low here, so only a drain can move data.
                    if (drn_s) begin
                        main_pc_d    = skid_pc_q;
                        main_instr_d = skid_instr_q;
                        skid_valid_d = 1'b0;
                    end else begin
                        skid_valid_d = skid_valid_q;
                    end
                end
                default: begin
                    // Skid without main is unreachable; recover to empty.
                    main_valid_d = 1'b0;
                    skid_valid_d = 1'b0;
                    main_instr_d = NOP_INSTR;
                end
            endcase
        end
        occupancy_d = {1'b0, main_valid_d} + {1'b0, skid_valid_d};
        in_ready_d  = ~skid_valid_d;
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            main_valid_q <= 1'b0;
            main_pc_q    <= {PC_W{1'b0}};
            main_instr_q <= NOP_INSTR;
            skid_valid_q <= 1'b0;
            skid_pc_q    <= {PC_W{1'b0}};
            skid_instr_q <= NOP_INSTR;
            occupancy_q  <= 2'd0;
            in_ready_q   <= 1'b1;
        end else begin
            main_valid_q <= main_valid_d;
            main_pc_q    <= main_pc_d;
            main_instr_q <= main_instr_d;
            skid_valid_q <= skid_valid_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
            occupancy_q  <= occupancy_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign bus.out_valid = main_valid_q;
    assign bus.out_pc    = main_pc_q;
    assign bus.out_instr = main_instr_q;
    assign bus.occupancy = occupancy_q;
    assign bus.in_ready  = in_ready_q;
endmodule

// File: tb/tb_if_id_skid_reg.sv
// Self-checking bench for if_id_skid_reg: directed scenarios plus random traffic,
// compared every cycle against a two-deep queue model of the stage.
module tb_if_id_skid_reg;
    localparam logic [31:0] NOP = 32'h00000013;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    if_id_skid_reg_if #(.PC_W(32), .INSTR_W(32)) bus ();

    if_id_skid_reg #(.PC_W(32), .INSTR_W(32), .NOP_INSTR(32'h00000013)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: held entries in acceptance order, head is what decode sees.
    logic [63:0] mq[$];
    logic [31:0] last_pc;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic rdy_before;
        check_eq("out_valid", {63'd0, bus.out_valid}, {63'd0, mq.size() > 0});
        check_eq("out_pc", {32'd0, bus.out_pc}, {32'd0, (mq.size() > 0) ? mq[0][63:32] : last_pc});
        check_eq("out_instr", {32'd0, bus.out_instr}, {32'd0, (mq.size() > 0) ? mq[0][31:0] : NOP});
        check_eq("occupancy", {62'd0, bus.occupancy}, 64'(mq.size()));
        check_eq("in_ready", {63'd0, bus.in_ready}, {63'd0, mq.size() < 2});
        rdy_before = bus.in_ready;
        bus.out_ready = ~bus.out_ready;
        #1;
        check_eq("in_ready_comb", {63'd0, bus.in_ready}, {63'd0, rdy_before});
        bus.out_ready = ~bus.out_ready;
        #1;
    endtask

    task automatic model_edge(input logic rst_v, input logic iv, input logic [31:0] pc,
                              input logic [31:0] instr, input logic fl, input logic ordy);
        logic acc;
        logic drn;
        if (!rst_v) begin
            mq.delete();
            last_pc = 32'd0;
        end else if (fl) begin
            mq.delete();
        end else begin
            acc = iv && (mq.size() < 2);
            drn = (mq.size() > 0) && ordy;
            if (drn) void'(mq.pop_front());
            if (acc) mq.push_back({pc, instr});
            if (mq.size() > 0) last_pc = mq[0][63:32];
        end
    endtask

    task automatic step(input logic rst_v, input logic iv, input logic [31:0] pc,
                        input logic [31:0] instr, input logic fl, input logic ordy);
        reset        = rst_v;
        bus.in_valid = iv;
        bus.in_pc    = pc;
        bus.in_instr = instr;
        bus.flush    = fl;
        bus.out_ready = ordy;
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_edge(rst_v, iv, pc, instr, fl, ordy);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        last_pc  = 32'd0;
        reset = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_pc = 32'h40;
        bus.in_instr = 32'h11111111;
        bus.flush = 1'b0;
        bus.out_ready = 1'b0;
        @(posedge clk);
        model_edge(1'b0, 1'b1, 32'h40, 32'h11111111, 1'b0, 1'b0);
        #1;

        // Reset held with fetch offering PC 0x40, then released.
        step(1'b0, 1'b1, 32'h40, 32'h11111111, 1'b0, 1'b0);
        check_eq("rst_out_pc", {32'd0, bus.out_pc}, 64'd0);
        check_eq("rst_out_instr", {32'd0, bus.out_instr}, {32'd0, NOP});
        check_eq("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        step(1'b1, 1'b1, 32'h40, 32'h11111111, 1'b0, 1'b1);
        check_eq("first_pc", {32'd0, bus.out_pc}, 64'h40);

        // Back-to-back streaming with decode always ready.
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b1, 32'(i * 4), 32'h000000A0 + 32'(i), 1'b0, 1'b1);
        check_eq("stream_last_pc", {32'd0, bus.out_pc}, 64'hC);
        check_eq("stream_occ", {62'd0, bus.occupancy}, 64'd1);
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

        // Decode stall pushes the next fetch into the skid slot.
        step(1'b1, 1'b1, 32'h4, 32'h000000B1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 32'h8, 32'h000000B2, 1'b0, 1'b0);
        check_eq("stall_occ", {62'd0, bus.occupancy}, 64'd2);
        check_eq("stall_in_ready", {63'd0, bus.in_ready}, 64'd0);
        check_eq("stall_pc", {32'd0, bus.out_pc}, 64'h4);
        step(1'b1, 1'b1, 32'hC, 32'h000000B3, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        check_eq("release_pc", {32'd0, bus.out_pc}, 64'h8);
        check_eq("release_in_ready", {63'd0, bus.in_ready}, 64'd1);

        // Flush with a full buffer discards the simultaneous fetch.
        step(1'b1, 1'b1, 32'h20, 32'h000000C0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'h24, 32'h000000C1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'h100, 32'h000000C2, 1'b1, 1'b1);
        check_eq("flush_valid", {63'd0, bus.out_valid}, 64'd0);
        check_eq("flush_occ", {62'd0, bus.occupancy}, 64'd0);
        check_eq("flush_instr", {32'd0, bus.out_instr}, {32'd0, NOP});
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        check_eq("flush_no_pc100", {63'd0, bus.out_valid}, 64'd0);

        // Flush and reset together: reset values only.
        step(1'b1, 1'b1, 32'h44, 32'h000000D0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 32'h48, 32'h000000D1, 1'b1, 1'b0);
        check_eq("rstflush_pc", {32'd0, bus.out_pc}, 64'd0);
        check_eq("rstflush_occ", {62'd0, bus.occupancy}, 64'd0);

        // Random traffic against the queue model.
        for (int n = 0; n < 10000; n++) begin
            step(($urandom_range(0, 199) != 0),
                 ($urandom_range(0, 3) != 0),
                 $urandom, $urandom,
                 ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 1) == 1));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
